xcr_vic: RTL and testbench
==========================

# xcr_vic

Parametrised vectored interrupt/exception controller for the LS1u XCR control-register space. It is the next generation of the 8-source controller and adds:
- configurable source counts
- per-source edge/level mode
- fixed priority with exceptions above interrupts
- an explicit acknowledge / end-of-interrupt (EOI) handshake with an in-service state

It sits between peripheral IRQ lines / CPU fault lines and the core's `INT` / `IVEC_ADDR` inputs, programmed over the 8-bit `cr_*` bus.

## Interface
Parameters:
- `N_INT`, default 16: interrupt sources; allowed values 8, 16, 24 or 32.
- `N_XCP`, default 8: exception sources; allowed values 1..8.

Ports (clock and reset first):
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `INT_ARR`  in  N_INT  interrupt request lines, synchronous to `clk`
- `XCP_ARR`  in  N_XCP  exception pulses; each 1-cycle pulse latches
- `int_ack`  in  1  core accepted the vector; sampled only in PEND
- `INT`  out  1  interrupt request to core, registered
- `IVEC_ADDR`  out  24  vector address, registered, stable while `INT`=1
- `in_service`  out  1  high in SVC state
- `cr_din`  in  8  write data
- `cr_dout`  out  8  read data, combinational
- `cr_adr`  in  5  register address
- `cr_we`  in  1  write strobe
- `cr_cs`  in  1  chip select

## Operation
Register map (k = byte index, 0..N_INT/8-1):
- `0x00` INTC = {GIE, 5'b0, IVESIZ[1:0]}; reset 0.
- `0x01` MCAUS, read-only: cause of the last acknowledged event; reset 0.
- `0x02`–`0x04` IVT0–IVT2: vector table base [7:0], [15:8], [23:16]; reset 0.
- `0x05` EOI: a write of any value ends service. Reads return 0.
- `0x08+k` INTE: enable bits; reset 0.
- `0x0C+k` INTP: pending bits; write-1-to-clear (W1C) for edge sources.
- `0x10+k` EDGE: 1 = edge mode, 0 = level mode; reset 0.
- `0x14` XCPP: exception pending bits, W1C.
- Unimplemented addresses and unused bits read 0; writes to them are ignored.

Pending logic:
- Edge source i: sets on the 0→1 transition of `INT_ARR[i] & INTE[i]`. The previous value is held in a register (reset 0). The bit is sticky. It clears on W1C or on acknowledge of source i.
- Level source i: `INTP[i]` = registered `INT_ARR[i] & INTE[i]`. It is not clearable by W1C or by acknowledge.
- `XCPP[j]`: sets on `XCP_ARR[j]`. It clears on W1C or on acknowledge. `XCP_ARR` is not maskable.
- If set and clear hit the same bit in the same cycle, set wins.

Arbitration:
- Any XCPP bit beats any INTP bit.
- Within a class, the highest index wins.
- Cause code = {2'b00, idx[5:0]} for an exception and {2'b01, idx[5:0]} for an interrupt.
- `IVEC_ADDR` = IVT + (code << (IVESIZ+2)), truncated to 24 bits (wraps modulo 2^24).

State machine:
- **IDLE**
  - Go to PEND when GIE=1 and any XCPP/INTP bit is set.
  - On that transition, register `INT`=1 and `IVEC_ADDR`, and latch the selected code.
- **PEND**
  - Selection is frozen; a newly arrived higher-priority source does not preempt it.
  - `int_ack`=1: go to SVC, `INT`←0, MCAUS←code, clear the selected edge/XCPP bit.
  - GIE written 0, or the selected pending bit drops (level source fell or was W1C'd) without `int_ack`: go to IDLE, `INT`←0. Re-arbitration is allowed on the next cycle.
  - `int_ack` has priority over the GIE=0 write in the same cycle.
- **SVC**
  - `INT`=0 and `in_service`=1.
  - Pending bits keep accumulating.
  - An EOI write goes to IDLE. EOI writes in IDLE or PEND are ignored.
  - GIE=0 does not leave SVC.

Reset values: `INT`=0, `IVEC_ADDR`=0, `in_service`=0, state IDLE, all registers 0. Reset may assert in any state and returns the block to IDLE within the same cycle.

## Timing
- A request sampled high at edge t sets INTP/XCPP at edge t. `INT` and `IVEC_ADDR` are valid after edge t+1. Latency is 2 clocks from input to `INT`.
- `int_ack` sampled at edge a: `INT`=0, `in_service`=1 and MCAUS valid after edge a.
- EOI write at edge e: IDLE after edge e. If a request is still pending, `INT` rises after edge e+1 at the earliest.
- Register writes take effect at the write edge. `cr_dout` follows `cr_adr` combinationally.

## Test plan
1. Edge source: N_INT=16, IVT=0x001000, IVESIZ=0, EDGE[5]=1, INTE[5]=1, GIE=1. Pulse `INT_ARR[5]` → 2 cycles later `INT`=1, `IVEC_ADDR`=0x001000+(0x45<<2)=0x001114. `int_ack` → INTP[5]=0, MCAUS=0x45, `in_service`=1.
2. Priority: `XCP_ARR[2]` and `INT_ARR[9]` (enabled) in the same cycle → vector for code 0x02 is taken first. After EOI, code 0x49 is served.
3. Level source: EDGE[3]=0, hold `INT_ARR[3]`=1 → ack and EOI leave INTP[3]=1, so `INT` re-asserts. Drop the input while in PEND → `INT`=0 the next cycle, state IDLE.
4. Wrap: IVT=0xFFFFF0, IVESIZ=3, code 0x47 → `IVEC_ADDR`=(0xFFFFF0+0x47<<5)&0xFFFFFF=0x0008D0.
5. W1C and set in the same cycle on INTP[7] → the bit stays 1. XCPP W1C clears only the written bits.
6. Assert `rst` while in SVC → all outputs 0 immediately. After release, a new request completes normally.

Source files
------------

// File: rtl/xcr_vic.sv
// xcr_vic: vectored interrupt/exception controller for the XCR register space.
// Fixed priority (exceptions over interrupts, highest index first) with an ack/EOI service handshake.
//
// state | meaning
// IDLE  | no request presented; arbitrates pending bits when GIE=1
// PEND  | INT raised with a frozen vector, waiting for int_ack
// SVC   | event acknowledged, in service until an EOI write
module xcr_vic #(
  parameter int N_INT = 16,
  parameter int N_XCP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_INT-1:0] INT_ARR,
  input  logic [N_XCP-1:0] XCP_ARR,
  input  logic             int_ack,
  output logic             INT,
  output logic [23:0]      IVEC_ADDR,
  output logic             in_service,
  input  logic [7:0]       cr_din,
  output logic [7:0]       cr_dout,
  input  logic [4:0]       cr_adr,
  input  logic             cr_we,
  input  logic             cr_cs
);

  localparam logic [4:0] A_INTC  = 5'h00;
  localparam logic [4:0] A_MCAUS = 5'h01;
  localparam logic [4:0] A_IVT0  = 5'h02;
  localparam logic [4:0] A_IVT1  = 5'h03;
  localparam logic [4:0] A_IVT2  = 5'h04;
  localparam logic [4:0] A_EOI   = 5'h05;
  localparam logic [4:0] A_INTE  = 5'h08;
  localparam logic [4:0] A_INTP  = 5'h0C;
  localparam logic [4:0] A_EDGE  = 5'h10;
  localparam logic [4:0] A_XCPP  = 5'h14;

  typedef enum logic [1:0] {IDLE, PEND, SVC} state_t;

  state_t           state;
  logic             wr;
  logic             gie;
  logic             gie_nxt;
  logic [1:0]       ivesiz;
  logic [7:0]       mcaus;
  logic [23:0]      ivt;
  logic [N_INT-1:0] inte;
  logic [N_INT-1:0] inte_nxt;
  logic [N_INT-1:0] edge_md;
  logic [N_INT-1:0] edge_nxt;
  logic [N_INT-1:0] intp;
  logic [N_INT-1:0] intp_nxt;
  logic [N_INT-1:0] prev;
  logic [N_INT-1:0] cur;
  logic [N_INT-1:0] w1c_int;
  logic [N_INT-1:0] ack_int;
  logic [N_XCP-1:0] xcpp;
  logic [N_XCP-1:0] xcpp_nxt;
  logic [N_XCP-1:0] w1c_xcp;
  logic [N_XCP-1:0] ack_xcp;
  logic             ack;
  logic             eoi_wr;
  logic             sel_valid;
  logic             sel_pend_nxt;
  logic [6:0]       sel_code;
  logic [6:0]       lat_code;
  logic [2:0]       shamt;
  logic [23:0]      vec_addr;

  assign wr = cr_cs & cr_we;

  // next-state of the configuration and pending registers; a set always beats a clear
  always_comb begin
    ack      = (state == PEND) && int_ack;
    eoi_wr   = wr && (cr_adr == A_EOI);
    gie_nxt  = (wr && cr_adr == A_INTC) ? cr_din[7] : gie;
    cur      = INT_ARR & inte;
    inte_nxt = inte;
    edge_nxt = edge_md;
    intp_nxt = intp;
    w1c_int  = '0;
    ack_int  = '0;
    for (int i = 0; i < N_INT; i++) begin
      if (wr && cr_adr == 5'(A_INTE + i / 8)) inte_nxt[i] = cr_din[i % 8];
      if (wr && cr_adr == 5'(A_EDGE + i / 8)) edge_nxt[i] = cr_din[i % 8];
      w1c_int[i] = wr && (cr_adr == 5'(A_INTP + i / 8)) && cr_din[i % 8];
      ack_int[i] = ack && lat_code[6] && (lat_code[5:0] == 6'(i));
      if (edge_md[i])
        intp_nxt[i] = (intp[i] & ~(w1c_int[i] | ack_int[i])) | (cur[i] & ~prev[i]);
      else
        intp_nxt[i] = cur[i];
    end
    xcpp_nxt = xcpp;
    w1c_xcp  = '0;
    ack_xcp  = '0;
    for (int j = 0; j < N_XCP; j++) begin
      w1c_xcp[j]  = wr && (cr_adr == A_XCPP) && cr_din[j];
      ack_xcp[j]  = ack && !lat_code[6] && (lat_code[5:0] == 6'(j));
      xcpp_nxt[j] = (xcpp[j] & ~(w1c_xcp[j] | ack_xcp[j])) | XCP_ARR[j];
    end
  end

  // exceptions are scanned last so any of them overrides every interrupt
  always_comb begin
    sel_valid = 1'b0;
    sel_code  = '0;
    for (int i = 0; i < N_INT; i++) begin
      if (intp[i]) begin
        sel_valid = 1'b1;
        sel_code  = {1'b1, 6'(i)};
      end
    end
    for (int j = 0; j < N_XCP; j++) begin
      if (xcpp[j]) begin
        sel_valid = 1'b1;
        sel_code  = {1'b0, 6'(j)};
      end
    end
    shamt    = {1'b0, ivesiz} + 3'd2;
    vec_addr = ivt + ({17'b0, sel_code} << shamt);
  end

  always_comb begin
    sel_pend_nxt = 1'b0;
    for (int i = 0; i < N_INT; i++)
      if (lat_code[6] && lat_code[5:0] == 6'(i)) sel_pend_nxt = intp_nxt[i];
    for (int j = 0; j < N_XCP; j++)
      if (!lat_code[6] && lat_code[5:0] == 6'(j)) sel_pend_nxt = xcpp_nxt[j];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gie     <= 1'b0;
      ivesiz  <= '0;
      ivt     <= '0;
      inte    <= '0;
      edge_md <= '0;
      intp    <= '0;
      prev    <= '0;
      xcpp    <= '0;
    end else begin
      gie <= gie_nxt;
      if (wr && cr_adr == A_INTC) ivesiz <= cr_din[1:0];
      if (wr && cr_adr == A_IVT0) ivt[7:0]   <= cr_din;
      if (wr && cr_adr == A_IVT1) ivt[15:8]  <= cr_din;
      if (wr && cr_adr == A_IVT2) ivt[23:16] <= cr_din;
      inte    <= inte_nxt;
      edge_md <= edge_nxt;
      intp    <= intp_nxt;
      prev    <= cur;
      xcpp    <= xcpp_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      INT        <= 1'b0;
      IVEC_ADDR  <= '0;
      in_service <= 1'b0;
      mcaus      <= '0;
      lat_code   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gie && sel_valid) begin
            state     <= PEND;
            INT       <= 1'b1;
            IVEC_ADDR <= vec_addr;
            lat_code  <= sel_code;
          end
        end
        PEND: begin
          if (int_ack) begin
            state      <= SVC;
            INT        <= 1'b0;
            in_service <= 1'b1;
            mcaus      <= {1'b0, lat_code};
          end else if (!gie_nxt || !sel_pend_nxt) begin
            state <= IDLE;
            INT   <= 1'b0;
          end
        end
        SVC: begin
          if (eoi_wr) begin
            state      <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          INT        <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    cr_dout = '0;
    case (cr_adr)
      A_INTC:  cr_dout = {gie, 5'b0, ivesiz};
      A_MCAUS: cr_dout = mcaus;
      A_IVT0:  cr_dout = ivt[7:0];
      A_IVT1:  cr_dout = ivt[15:8];
      A_IVT2:  cr_dout = ivt[23:16];
      default: cr_dout = '0;
    endcase
    for (int i = 0; i < N_INT; i++) begin
      if (cr_adr == 5'(A_INTE + i / 8)) cr_dout[i % 8] = inte[i];
      if (cr_adr == 5'(A_INTP + i / 8)) cr_dout[i % 8] = intp[i];
      if (cr_adr == 5'(A_EDGE + i / 8)) cr_dout[i % 8] = edge_md[i];
    end
    for (int j = 0; j < N_XCP; j++)
      if (cr_adr == A_XCPP) cr_dout[j] = xcpp[j];
  end

endmodule

// File: tb/tb_xcr_vic.sv
// Directed bench for xcr_vic (N_INT=16, N_XCP=8): edge/level sources, priority,
// vector wrap, W1C races and reset during service, checked against hand-computed values.
module tb_xcr_vic;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] INT_ARR;
  logic [7:0]  XCP_ARR;
  logic        int_ack;
  logic        INT;
  logic [23:0] IVEC_ADDR;
  logic        in_service;
  logic [7:0]  cr_din;
  logic [7:0]  cr_dout;
  logic [4:0]  cr_adr;
  logic        cr_we;
  logic        cr_cs;

  int n_tests = 0;
  int n_fail  = 0;

  xcr_vic #(.N_INT(16), .N_XCP(8)) dut (
    .clk(clk), .rst(rst), .INT_ARR(INT_ARR), .XCP_ARR(XCP_ARR), .int_ack(int_ack),
    .INT(INT), .IVEC_ADDR(IVEC_ADDR), .in_service(in_service),
    .cr_din(cr_din), .cr_dout(cr_dout), .cr_adr(cr_adr), .cr_we(cr_we), .cr_cs(cr_cs)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [4:0] a, input logic [7:0] exp);
    cr_adr = a;
    #1;
    check(tag, 24'(cr_dout), 24'(exp));
  endtask

  task automatic cr_write(input logic [4:0] a, input logic [7:0] d);
    cr_cs  = 1'b1;
    cr_we  = 1'b1;
    cr_adr = a;
    cr_din = d;
    tick();
    cr_cs = 1'b0;
    cr_we = 1'b0;
  endtask

  task automatic do_ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; INT_ARR = '0; XCP_ARR = '0; int_ack = 1'b0;
    cr_din = '0; cr_adr = '0; cr_we = 1'b0; cr_cs = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_int", 24'(INT), 24'd0);
    check("rst_ivec", IVEC_ADDR, 24'd0);
    check("rst_svc", 24'(in_service), 24'd0);
    rst = 1'b0;
    tick();
    check_reg("rst_intc", 5'h00, 8'h00);

    // edge source 5
    cr_write(5'h03, 8'h10);
    cr_write(5'h08, 8'hA8);
    cr_write(5'h09, 8'h02);
    cr_write(5'h10, 8'hA0);
    cr_write(5'h11, 8'h02);
    cr_write(5'h0A, 8'hFF);
    check_reg("unimpl_inte2", 5'h0A, 8'h00);
    cr_write(5'h00, 8'h80);
    check_reg("intc_rd", 5'h00, 8'h80);
    check_reg("ivt1_rd", 5'h03, 8'h10);
    INT_ARR[5] = 1'b1;
    tick();
    INT_ARR[5] = 1'b0;
    check("t1_int_early", 24'(INT), 24'd0);
    check_reg("t1_intp_set", 5'h0C, 8'h20);
    tick();
    check("t1_int", 24'(INT), 24'd1);
    check("t1_ivec", IVEC_ADDR, 24'h001114);
    do_ack();
    check("t1_int_ack", 24'(INT), 24'd0);
    check("t1_svc", 24'(in_service), 24'd1);
    check_reg("t1_mcaus", 5'h01, 8'h45);
    check_reg("t1_intp_clr", 5'h0C, 8'h00);
    cr_write(5'h05, 8'h00);
    check("t1_eoi", 24'(in_service), 24'd0);
    check_reg("eoi_rd", 5'h05, 8'h00);

    // exception beats interrupt
    XCP_ARR[2] = 1'b1;
    INT_ARR[9] = 1'b1;
    tick();
    XCP_ARR = '0;
    INT_ARR[9] = 1'b0;
    check_reg("t2_xcpp", 5'h14, 8'h04);
    check_reg("t2_intp1", 5'h0D, 8'h02);
    tick();
    check("t2_int", 24'(INT), 24'd1);
    check("t2_ivec_x", IVEC_ADDR, 24'h001008);
    do_ack();
    check_reg("t2_mcaus_x", 5'h01, 8'h02);
    check_reg("t2_xcpp_clr", 5'h14, 8'h00);
    check_reg("t2_intp1_kept", 5'h0D, 8'h02);
    cr_write(5'h05, 8'h00);
    check("t2_eoi_gap", 24'(INT), 24'd0);
    tick();
    check("t2_int2", 24'(INT), 24'd1);
    check("t2_ivec_i", IVEC_ADDR, 24'h001124);
    do_ack();
    check_reg("t2_mcaus_i", 5'h01, 8'h49);
    check_reg("t2_intp1_clr", 5'h0D, 8'h00);
    cr_write(5'h05, 8'h00);

    // level source 3
    INT_ARR[3] = 1'b1;
    tick();
    tick();
    check("t3_int", 24'(INT), 24'd1);
    check("t3_ivec", IVEC_ADDR, 24'h00110C);
    do_ack();
    check_reg("t3_mcaus", 5'h01, 8'h43);
    check_reg("t3_intp_held", 5'h0C, 8'h08);
    cr_write(5'h05, 8'h00);
    check("t3_eoi_gap", 24'(INT), 24'd0);
    tick();
    check("t3_reassert", 24'(INT), 24'd1);
    INT_ARR[3] = 1'b0;
    tick();
    check("t3_drop_int", 24'(INT), 24'd0);
    check("t3_drop_svc", 24'(in_service), 24'd0);
    check_reg("t3_drop_intp", 5'h0C, 8'h00);
    tick();
    check("t3_idle", 24'(INT), 24'd0);

    // W1C races
    cr_write(5'h00, 8'h00);
    cr_cs = 1'b1; cr_we = 1'b1; cr_adr = 5'h0C; cr_din = 8'h80;
    INT_ARR[7] = 1'b1;
    tick();
    cr_cs = 1'b0; cr_we = 1'b0;
    INT_ARR[7] = 1'b0;
    check_reg("t5_set_wins", 5'h0C, 8'h80);
    cr_write(5'h0C, 8'h80);
    check_reg("t5_w1c", 5'h0C, 8'h00);
    XCP_ARR = 8'h05;
    tick();
    XCP_ARR = '0;
    check_reg("t5_xcpp", 5'h14, 8'h05);
    cr_write(5'h14, 8'h01);
    check_reg("t5_xcpp_w1c", 5'h14, 8'h04);
    cr_write(5'h14, 8'h04);
    check_reg("t5_xcpp_zero", 5'h14, 8'h00);

    // vector wrap, GIE drop in PEND
    cr_write(5'h02, 8'hF0);
    cr_write(5'h03, 8'hFF);
    cr_write(5'h04, 8'hFF);
    cr_write(5'h00, 8'h83);
    check_reg("t4_intc", 5'h00, 8'h83);
    INT_ARR[7] = 1'b1;
    tick();
    INT_ARR[7] = 1'b0;
    tick();
    check("t4_int", 24'(INT), 24'd1);
    check("t4_ivec_wrap", IVEC_ADDR, 24'h0008D0);
    cr_write(5'h00, 8'h03);
    check("t4_gie_off", 24'(INT), 24'd0);
    cr_write(5'h00, 8'h83);
    tick();
    check("t4_rearb", 24'(INT), 24'd1);
    check("t4_ivec2", IVEC_ADDR, 24'h0008D0);
    do_ack();
    check_reg("t4_mcaus", 5'h01, 8'h47);
    check("t4_svc", 24'(in_service), 24'd1);

    // reset in SVC
    #2 rst = 1'b1;
    #1;
    check("t6_rst_int", 24'(INT), 24'd0);
    check("t6_rst_svc", 24'(in_service), 24'd0);
    check("t6_rst_ivec", IVEC_ADDR, 24'd0);
    check_reg("t6_rst_mcaus", 5'h01, 8'h00);
    #1 rst = 1'b0;
    tick();
    cr_write(5'h08, 8'h20);
    cr_write(5'h10, 8'h20);
    cr_write(5'h00, 8'h80);
    INT_ARR[5] = 1'b1;
    tick();
    INT_ARR[5] = 1'b0;
    tick();
    check("t6_int", 24'(INT), 24'd1);
    check("t6_ivec", IVEC_ADDR, 24'h000114);
    do_ack();
    check_reg("t6_mcaus", 5'h01, 8'h45);
    check("t6_svc", 24'(in_service), 24'd1);
    cr_write(5'h05, 8'h00);
    check("t6_eoi", 24'(in_service), 24'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
